// File: rtl/mem_responder.sv
// Memory-side responder for the CU strobes RD/WR/RDM, with separate instruction and data banks.
// Optional wait states are enabled with `define MEM_WAIT_EN (WAIT state plus counter); without it every request completes in one cycle.
module mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RD,
    input  logic              WR,
    input  logic              RDM,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wack,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(2 * DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t state, state_nxt;

    // imem occupies words [0, DEPTH), dmem occupies [DEPTH, 2*DEPTH); imem is never written here
    logic [DATA_W-1:0] mem [2*DEPTH];

    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              dsel_p0;
    logic              op_rd_p0;
    logic [IDX_W-1:0]  idx;

    logic request, legal, accept, reject;
    logic in_range;

    assign request  = RD | WR;
    assign in_range = (32'(addr) < 32'(DEPTH));
    assign legal    = ((RD && !WR) || (WR && !RD && RDM)) && in_range;
    assign accept   = (state == IDLE) && request && legal;
    assign reject   = (state == IDLE) && request && !legal;

    assign idx = IDX_W'(addr_p0) + (dsel_p0 ? IDX_W'(DEPTH) : '0);

`ifdef MEM_WAIT_EN
    localparam int CNT_W    = (WAIT_CYC > 2) ? $clog2(WAIT_CYC) : 1;
    localparam int CNT_LOAD = (WAIT_CYC > 1) ? (WAIT_CYC - 1) : 0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(CNT_LOAD);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (state == WAIT);
`else
    localparam int unused_wait_cyc = WAIT_CYC;

    assign busy = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef MEM_WAIT_EN
                    state_nxt = WAIT;
`else
                    state_nxt = DONE;
`endif
                end
            end
            WAIT: begin
`ifdef MEM_WAIT_EN
                if (cnt == '0) state_nxt = DONE;
`else
                state_nxt = IDLE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // control and completion outputs; rdata only moves on a completed read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            wack   <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            state  <= state_nxt;
            rvalid <= (state == DONE) && op_rd_p0;
            wack   <= (state == DONE) && !op_rd_p0;
            err    <= reject;
            if (state == DONE && op_rd_p0) rdata <= mem[idx];
        end
    end

    // request capture
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= addr;
            wdata_p0 <= wdata;
            dsel_p0  <= RDM;
            op_rd_p0 <= RD;
        end
    end

    // write commit; a reset during WAIT/DONE returns state to IDLE so nothing lands
    always_ff @(posedge clk) begin
        if (state == DONE && !op_rd_p0) mem[idx] <= wdata_p0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder; adapts expected latency and busy to MEM_WAIT_EN.
module tb_mem_responder;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 128;
    localparam int WAIT_CYC = 2;
`ifdef MEM_WAIT_EN
    localparam int LAT      = WAIT_CYC + 1;
    localparam int BUSY_CYC = WAIT_CYC;
`else
    localparam int LAT      = 1;
    localparam int BUSY_CYC = 0;
`endif

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_ERR  = 2;
    localparam int K_NONE = 3;

    logic              clk;
    logic              rst;
    logic              RD, WR, RDM;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid, wack, busy, err;

    mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .RD    (RD),
        .WR    (WR),
        .RDM   (RDM),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rvalid(rvalid),
        .wack  (wack),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // completion monitor: every rvalid/wack/err pulse must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        int   kind;
        if (!rst && (rvalid || wack || err)) begin
            if (sb.size() == 0) begin
                check("spurious_evt", {29'b0, rvalid, wack, err}, 32'd0);
            end else begin
                e    = sb.pop_front();
                kind = rvalid ? K_RD : (wack ? K_WR : K_ERR);
                check("evt_kind", kind, e.kind);
                check("evt_cycle", cyc, e.due);
                if (kind == K_RD) check("evt_rdata", rdata, e.data);
            end
        end
    end

    task automatic req(input logic rd, input logic wr, input logic rdm,
                       input logic [7:0] a, input logic [7:0] d,
                       input int kind, input logic [7:0] exp_data);
        exp_t e;
        @(negedge clk);
        RD = rd; WR = wr; RDM = rdm; addr = a; wdata = d;
        e.kind = kind;
        e.data = exp_data;
        e.due  = (kind == K_ERR) ? cyc + 1 : cyc + 1 + LAT;
        if (kind != K_NONE) sb.push_back(e);
        @(posedge clk);
        #1;
        RD = 1'b0; WR = 1'b0;
    endtask

    task automatic settle();
        repeat (LAT + 2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        RD = 1'b0; WR = 1'b0; RDM = 1'b0; addr = '0; wdata = '0;
        dut.mem[16]         = 8'h52;
        dut.mem[1]          = 8'h11;
        dut.mem[2]          = 8'h22;
        dut.mem[3]          = 8'h33;
        dut.mem[32]         = 8'h77;
        dut.mem[DEPTH + 5]  = 8'hC3;
        dut.mem[DEPTH + 32] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", rvalid, 32'h0);
        check("rst_wack", wack, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_err", err, 32'h0);

        // instruction fetch with busy profile
        req(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, K_RD, 8'h52);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy_fetch", busy, (k < BUSY_CYC));
        end
        settle();
        check("rdata_hold", rdata, 32'h52);

        // dmem write then read back
        req(1'b0, 1'b1, 1'b1, 8'h20, 8'hA5, K_WR, 8'h00);
        settle();
        check("dmem_20", dut.mem[DEPTH + 32], 32'hA5);
        check("rdata_after_wr", rdata, 32'h52);
        req(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, K_RD, 8'hA5);
        settle();
        check("imem_20", dut.mem[32], 32'h77);

        // illegal requests
        req(1'b0, 1'b1, 1'b0, 8'h03, 8'hEE, K_ERR, 8'h00);
        settle();
        check("imem_03", dut.mem[3], 32'h33);
        req(1'b1, 1'b1, 1'b1, 8'h20, 8'h99, K_ERR, 8'h00);
        settle();
        check("rdata_rdwr", rdata, 32'hA5);
        check("dmem_20_rdwr", dut.mem[DEPTH + 32], 32'hA5);
        req(1'b1, 1'b0, 1'b0, 8'h80, 8'h00, K_ERR, 8'h00);
        settle();
        req(1'b0, 1'b1, 1'b1, 8'h80, 8'h44, K_ERR, 8'h00);
        settle();
        check("rdata_oob", rdata, 32'hA5);

        // second request while the first is in flight is dropped
        req(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, K_RD, 8'h11);
        req(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, K_NONE, 8'h00);
        settle();
        check("rdata_drop", rdata, 32'h11);

        // last-address boundary read
        dut.mem[DEPTH - 1] = 8'h7E;
        req(1'b1, 1'b0, 1'b0, 8'h7F, 8'h00, K_RD, 8'h7E);
        settle();

        // asynchronous reset aborts an in-flight write
        req(1'b0, 1'b1, 1'b1, 8'h05, 8'h5A, K_NONE, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rdata", rdata, 32'h0);
        check("abort_rvalid", rvalid, 32'h0);
        check("abort_wack", wack, 32'h0);
        check("abort_busy", busy, 32'h0);
        check("abort_err", err, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("dmem_05", dut.mem[DEPTH + 5], 32'hC3);

        check("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
